// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W forms.
// It produces one quotient bit per cycle, MSB first, on magnitudes. Signs are fixed up
// when the result is registered. Divide-by-zero and signed overflow skip the
// iteration and finish one cycle after acceptance.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   div_ready    start request (level), sampled only in IDLE
//   inst_op_f3   {opcode[6:0], funct3}, decoded at acceptance
//   div_op1/2    dividend / divisor, latched at acceptance
//   div_result   quotient or remainder, held until the next completion
//   div_finish   one-cycle pulse marking div_result valid
//   busy_o       high from the acceptance edge through the DONE cycle
module divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_ready,
  input  logic [9:0]      inst_op_f3,
  input  logic [XLEN-1:0] div_op1,
  input  logic [XLEN-1:0] div_op2,
  output logic [XLEN-1:0] div_result,
  output logic            div_finish,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [63:0] rem, dvd, dsr;
  logic [5:0]  cnt;
  logic        w_r, rem_r, q_neg, r_neg;

  // decode of the request as presented in IDLE
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        op_w, op_ok, sgn, rem_op;
  logic [63:0] a_ext, b_ext, a_sx, a_abs, b_abs, spec_res;
  logic        s1, s2, div0, ovf;

  always_comb begin
    opc    = inst_op_f3[9:3];
    f3     = inst_op_f3[2:0];
    op_w   = (opc == 7'b0111011);
    op_ok  = ((opc == 7'b0110011) || op_w) && f3[2];
    sgn    = ~f3[0];
    rem_op = f3[1];
    a_sx   = op_w ? {{32{div_op1[31]}}, div_op1[31:0]} : div_op1;
    a_ext  = (op_w && !sgn) ? {32'h0, div_op1[31:0]} : a_sx;
    b_ext  = op_w ? (sgn ? {{32{div_op2[31]}}, div_op2[31:0]} : {32'h0, div_op2[31:0]})
                  : div_op2;
    // unsigned operands never count as negative, whatever their top bit
    s1     = sgn & a_ext[63];
    s2     = sgn & b_ext[63];
    a_abs  = s1 ? -a_ext : a_ext;
    b_abs  = s2 ? -b_ext : b_ext;
    div0   = (b_ext == 64'h0);
    // the W-form most-negative value is already sign-extended in a_ext
    ovf    = sgn && (b_ext == '1) &&
             (a_ext == (op_w ? 64'hFFFFFFFF80000000 : 64'h8000000000000000));
    // div-by-0: Q=all ones, R=dividend; overflow: Q=dividend, R=0
    if (div0) spec_res = rem_op ? a_sx : '1;
    else      spec_res = rem_op ? 64'h0 : a_sx;
  end

  // one restoring step; the trial remainder needs 65 bits before the compare
  logic        msb, ge, last;
  logic [64:0] trial;
  logic [63:0] rem_nx, dvd_nx, q_f, r_f, res, fin_res;

  always_comb begin
    msb     = w_r ? dvd[31] : dvd[63];
    trial   = {rem, msb};
    ge      = (trial >= {1'b0, dsr});
    // when ge holds, the difference fits in 64 bits
    rem_nx  = ge ? (trial[63:0] - dsr) : trial[63:0];
    // quotient bits shift in at the bottom as dividend bits leave the top
    dvd_nx  = {dvd[62:0], ge};
    q_f     = q_neg ? -dvd_nx : dvd_nx;
    r_f     = r_neg ? -rem_nx : rem_nx;
    res     = rem_r ? r_f : q_f;
    fin_res = w_r ? {{32{res[31]}}, res[31:0]} : res;
    last    = (cnt == (w_r ? 6'd31 : 6'd63));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      dvd        <= '0;
      dsr        <= '0;
      cnt        <= '0;
      w_r        <= 1'b0;
      rem_r      <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_result <= '0;
      div_finish <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_finish <= 1'b0;
          if (div_ready && op_ok) begin
            busy_o <= 1'b1;
            w_r    <= op_w;
            rem_r  <= rem_op;
            q_neg  <= s1 ^ s2;
            r_neg  <= s1;
            rem    <= '0;
            dvd    <= a_abs;
            dsr    <= b_abs;
            cnt    <= '0;
            if (div0 || ovf) begin
              div_result <= spec_res;
              div_finish <= 1'b1;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          dvd <= dvd_nx;
          cnt <= cnt + 6'd1;
          if (last) begin
            div_result <= fin_res;
            div_finish <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          div_finish <= 1'b0;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
